// File: rtl/sram_array_pkg.sv
// Shared types and helpers for the 1R1W array model and its init controller.
// Holds the sweep FSM state encoding, geometry helpers and the clear pattern.
package sram_array_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_state_t;

  localparam logic CLEAR_BIT = 1'b0;

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_mask_seg(input int width, input int gran);
    return width / gran;
  endfunction

endpackage

// File: rtl/sram_array_init_ctrl.sv
// Post-reset clearing sweep: one entry per cycle, then init_done stays high.
// Latency DEPTH cycles from reset release; no backpressure, the sweep always advances.
module sram_array_init_ctrl
  import sram_array_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          init_done,
  output logic          sweep_en,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  init_state_t   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sweep_en  = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_en = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      ST_READY: init_done = 1'b1;
      default:  state_d = ST_INIT;
    endcase
  end

  assign sweep_addr = ptr_q;

endmodule

// File: rtl/sram_1r1w_array.sv
// 1R1W masked array, read latency 1 (OUT_REG=0) or 2 (OUT_REG=1), full-rate reads, no backpressure.
// ARRAY_RW_BYPASS_EN: same-address same-cycle read sees the merged new data instead of the old word.
module sram_1r1w_array
  import sram_array_pkg::*;
#(
  parameter  int DEPTH     = 64,
  parameter  int WIDTH     = 1024,
  parameter  int MASK_GRAN = 1024,
  parameter  int OUT_REG   = 0,
  localparam int AW        = calc_aw(DEPTH),
  localparam int MASK_SEG  = calc_mask_seg(WIDTH, MASK_GRAN)
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic                init_done,
  input  logic                R0_en,
  input  logic [AW-1:0]       R0_addr,
  output logic                R0_valid,
  output logic [WIDTH-1:0]    R0_data,
  input  logic                W0_en,
  input  logic [AW-1:0]       W0_addr,
  input  logic [MASK_SEG-1:0] W0_mask,
  input  logic [WIDTH-1:0]    W0_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic                sweep_en;
  logic [AW-1:0]       sweep_addr;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [MASK_SEG-1:0] wr_mask;
  logic [WIDTH-1:0]    wr_data;
  logic                w_in_range, r_in_range, rd_fire;
  logic [WIDTH-1:0]    rd_word;
  logic                s1_vld;
  logic [WIDTH-1:0]    s1_dat;

  sram_array_init_ctrl #(.DEPTH(DEPTH)) u_init_ctrl (
    .clock      (clock),
    .reset_n    (reset_n),
    .init_done  (init_done),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  assign w_in_range = ({1'b0, W0_addr} < (AW + 1)'(DEPTH));
  assign r_in_range = ({1'b0, R0_addr} < (AW + 1)'(DEPTH));
  assign rd_fire    = init_done & R0_en;

  // The sweep owns the write port until init_done; user writes are dropped meanwhile.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = W0_addr;
    wr_mask = W0_mask;
    wr_data = W0_data;
    if (sweep_en) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr;
      wr_mask = '1;
      wr_data = {WIDTH{CLEAR_BIT}};
    end else if (init_done && W0_en && w_in_range) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < MASK_SEG; i++) begin
        if (wr_mask[i]) mem[wr_addr][i*MASK_GRAN +: MASK_GRAN] <= wr_data[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  always_comb begin
    rd_word = {WIDTH{CLEAR_BIT}};
    if (r_in_range) begin
      rd_word = mem[R0_addr];
`ifdef ARRAY_RW_BYPASS_EN
      if (wr_en && (wr_addr == R0_addr)) begin
        for (int i = 0; i < MASK_SEG; i++) begin
          if (wr_mask[i]) rd_word[i*MASK_GRAN +: MASK_GRAN] = wr_data[i*MASK_GRAN +: MASK_GRAN];
        end
      end
`endif
    end
  end

  // Data registers only load on a read so the last result holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= rd_fire;
      if (rd_fire) s1_dat <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             s2_vld;
      logic [WIDTH-1:0] s2_dat;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s2_vld <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_dat <= s1_dat;
        end
      end
      assign R0_valid = s2_vld;
      assign R0_data  = s2_dat;
    end else begin : g_no_out_reg
      assign R0_valid = s1_vld;
      assign R0_data  = s1_dat;
    end
  endgenerate

endmodule

// File: tb/tb_sram_1r1w_array.sv
// Directed bench: u0 is DEPTH=64/WIDTH=32/GRAN=8/OUT_REG=0, u1 is DEPTH=48/WIDTH=1024/GRAN=256/OUT_REG=1.
module tb_sram_1r1w_array;

  logic clock;
  logic reset_n;

  logic        init_done0, r_en0, r_vld0, w_en0;
  logic [5:0]  r_addr0, w_addr0;
  logic [31:0] r_data0, w_data0;
  logic [3:0]  w_mask0;

  logic          init_done1, r_en1, r_vld1, w_en1;
  logic [5:0]    r_addr1, w_addr1;
  logic [1023:0] r_data1, w_data1;
  logic [3:0]    w_mask1;

  int checks = 0;
  int errors = 0;

  logic [1023:0] exp1;
  logic [31:0]   exp0;

  sram_1r1w_array #(.DEPTH(64), .WIDTH(32), .MASK_GRAN(8), .OUT_REG(0)) u0 (
    .clock(clock), .reset_n(reset_n), .init_done(init_done0),
    .R0_en(r_en0), .R0_addr(r_addr0), .R0_valid(r_vld0), .R0_data(r_data0),
    .W0_en(w_en0), .W0_addr(w_addr0), .W0_mask(w_mask0), .W0_data(w_data0)
  );

  sram_1r1w_array #(.DEPTH(48), .WIDTH(1024), .MASK_GRAN(256), .OUT_REG(1)) u1 (
    .clock(clock), .reset_n(reset_n), .init_done(init_done1),
    .R0_en(r_en1), .R0_addr(r_addr1), .R0_valid(r_vld1), .R0_data(r_data1),
    .W0_en(w_en1), .W0_addr(w_addr1), .W0_mask(w_mask1), .W0_data(w_data1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    r_en0 = 0; r_addr0 = '0; w_en0 = 0; w_addr0 = '0; w_mask0 = '0; w_data0 = '0;
    r_en1 = 0; r_addr1 = '0; w_en1 = 0; w_addr1 = '0; w_mask1 = '0; w_data1 = '0;
    #23;
    chk("rst_init_done0", 1024'(init_done0), 1024'(0));
    chk("rst_init_done1", 1024'(init_done1), 1024'(0));
    chk("rst_valid0", 1024'(r_vld0), 1024'(0));
    chk("rst_valid1", 1024'(r_vld1), 1024'(0));
    chk("rst_data0", 1024'(r_data0), 1024'(0));
    chk("rst_data1", r_data1, 1024'(0));

    // Release; reads and writes to addr 3 during INIT must be ignored.
    tick();
    reset_n = 1'b1;
    r_en0 = 1; r_addr0 = 6'd3; w_en0 = 1; w_addr0 = 6'd3; w_mask0 = '1; w_data0 = '1;
    r_en1 = 1; r_addr1 = 6'd3; w_en1 = 1; w_addr1 = 6'd3; w_mask1 = '1; w_data1 = '1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 30) begin
        r_en0 = 0; w_en0 = 0; r_en1 = 0; w_en1 = 0;
      end
      chk("sweep_init_done0", 1024'(init_done0), 1024'(k >= 64));
      chk("sweep_init_done1", 1024'(init_done1), 1024'(k >= 48));
      chk("init_no_valid0", 1024'(r_vld0), 1024'(0));
      chk("init_no_valid1", 1024'(r_vld1), 1024'(0));
    end

    // Every entry reads back as zero.
    for (int a = 0; a < 64; a++) begin
      r_en0 = 1; r_addr0 = 6'(a);
      tick();
      chk("clear_valid0", 1024'(r_vld0), 1024'(1));
      chk("clear_data0", 1024'(r_data0), 1024'(0));
    end
    r_en0 = 0;
    for (int a = 0; a < 48; a++) begin
      r_en1 = 1; r_addr1 = 6'(a);
      tick();
      if (a > 0) begin
        chk("clear_valid1", 1024'(r_vld1), 1024'(1));
        chk("clear_data1", r_data1, 1024'(0));
      end
    end
    r_en1 = 0;
    tick();
    chk("clear_last_valid1", 1024'(r_vld1), 1024'(1));
    chk("clear_last_data1", r_data1, 1024'(0));
    tick();
    chk("clear_end_valid1", 1024'(r_vld1), 1024'(0));

    // Masked writes to addr 5.
    w_en0 = 1; w_addr0 = 6'd5; w_data0 = '1; w_mask0 = 4'b0110;
    w_en1 = 1; w_addr1 = 6'd5; w_data1 = '1; w_mask1 = 4'b0101;
    tick();
    w_en0 = 0; w_en1 = 0;
    r_en0 = 1; r_addr0 = 6'd5; r_en1 = 1; r_addr1 = 6'd5;
    tick();
    r_en0 = 0; r_en1 = 0;
    chk("mask_valid0", 1024'(r_vld0), 1024'(1));
    chk("mask_data0", 1024'(r_data0), 1024'(32'h00FF_FF00));
    chk("mask_lat_valid1", 1024'(r_vld1), 1024'(0));
    tick();
    exp1 = '0;
    exp1[255:0] = '1;
    exp1[767:512] = '1;
    chk("mask_valid1", 1024'(r_vld1), 1024'(1));
    chk("mask_data1", r_data1, exp1);
    chk("mask_pulse_valid0", 1024'(r_vld0), 1024'(0));

    // Back-to-back reads through the output register.
    for (int i = 1; i <= 3; i++) begin
      w_en1 = 1; w_addr1 = 6'(i); w_data1 = 1024'(9 + i); w_mask1 = '1;
      tick();
    end
    w_en1 = 0;
    r_en1 = 1; r_addr1 = 6'd1;
    tick();
    chk("pipe_c1_valid", 1024'(r_vld1), 1024'(0));
    r_addr1 = 6'd2;
    tick();
    chk("pipe_c2_valid", 1024'(r_vld1), 1024'(1));
    chk("pipe_c2_data", r_data1, 1024'(32'hA));
    r_addr1 = 6'd3;
    tick();
    chk("pipe_c3_valid", 1024'(r_vld1), 1024'(1));
    chk("pipe_c3_data", r_data1, 1024'(32'hB));
    r_en1 = 0;
    tick();
    chk("pipe_c4_valid", 1024'(r_vld1), 1024'(1));
    chk("pipe_c4_data", r_data1, 1024'(32'hC));
    tick();
    chk("pipe_c5_valid", 1024'(r_vld1), 1024'(0));
    chk("hold_data", r_data1, 1024'(32'hC));
    w_en1 = 1; w_addr1 = 6'd3; w_data1 = 1024'(32'hD); w_mask1 = '1;
    tick();
    w_en1 = 0;
    tick();
    chk("hold_after_write_valid", 1024'(r_vld1), 1024'(0));
    chk("hold_after_write_data", r_data1, 1024'(32'hC));

    // Same-address read and write in one cycle.
    w_en0 = 1; w_addr0 = 6'd7; w_data0 = 32'h1122_3344; w_mask0 = '1;
    w_en1 = 1; w_addr1 = 6'd7; w_data1 = 1024'(32'h11); w_mask1 = '1;
    tick();
    w_data0 = 32'hAABB_CCDD; w_mask0 = 4'b0011; r_en0 = 1; r_addr0 = 6'd7;
    w_data1 = 1024'(32'h55); r_en1 = 1; r_addr1 = 6'd7;
    tick();
    w_en0 = 0; w_en1 = 0; r_en0 = 0; r_en1 = 0;
`ifdef ARRAY_RW_BYPASS_EN
    exp0 = 32'h1122_CCDD;
    exp1 = 1024'(32'h55);
`else
    exp0 = 32'h1122_3344;
    exp1 = 1024'(32'h11);
`endif
    chk("rw_same_valid0", 1024'(r_vld0), 1024'(1));
    chk("rw_same_data0", 1024'(r_data0), 1024'(exp0));
    tick();
    chk("rw_same_valid1", 1024'(r_vld1), 1024'(1));
    chk("rw_same_data1", r_data1, exp1);
    r_en0 = 1;
    tick();
    r_en0 = 0;
    chk("rw_after_data0", 1024'(r_data0), 1024'(32'h1122_CCDD));

    // Out-of-range write dropped, out-of-range read returns zero.
    w_en1 = 1; w_addr1 = 6'd47; w_data1 = 1024'(32'h47); w_mask1 = '1;
    tick();
    w_addr1 = 6'd50; w_data1 = '1;
    tick();
    w_en1 = 0;
    r_en1 = 1; r_addr1 = 6'd50;
    tick();
    r_addr1 = 6'd47;
    tick();
    r_en1 = 0;
    chk("oor_valid", 1024'(r_vld1), 1024'(1));
    chk("oor_data", r_data1, 1024'(0));
    tick();
    chk("oor_neighbor_valid", 1024'(r_vld1), 1024'(1));
    chk("oor_neighbor_data", r_data1, 1024'(32'h47));

    // Reset with a read in flight.
    r_en1 = 1; r_addr1 = 6'd47;
    tick();
    r_en1 = 0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid1", 1024'(r_vld1), 1024'(0));
    chk("midrst_data1", r_data1, 1024'(0));
    chk("midrst_init_done1", 1024'(init_done1), 1024'(0));
    chk("midrst_init_done0", 1024'(init_done0), 1024'(0));
    chk("midrst_data0", 1024'(r_data0), 1024'(0));
    tick();
    tick();
    chk("inflight_dropped", 1024'(r_vld1), 1024'(0));
    reset_n = 1'b1;
    r_en1 = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("init_read_valid", 1024'(r_vld1), 1024'(0));
    end

    // Reset again at sweep pointer 20; the sweep restarts from 0.
    #2;
    reset_n = 1'b0;
    #1;
    chk("init_rst_init_done", 1024'(init_done1), 1024'(0));
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      tick();
      if (k == 47) r_en1 = 0;
      chk("restart_init_done1", 1024'(init_done1), 1024'(k >= 48));
      chk("restart_no_valid1", 1024'(r_vld1), 1024'(0));
    end
    r_en1 = 1; r_addr1 = 6'd47;
    tick();
    r_en1 = 0;
    tick();
    chk("restart_cleared_valid", 1024'(r_vld1), 1024'(1));
    chk("restart_cleared_data", r_data1, 1024'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_array.md
# sram_1r1w_array

Parametrised single-clock 1-read/1-write memory array model with per-segment write mask, selectable read latency and a post-reset clearing sweep. It is the next-generation replacement for the fixed-geometry 1R1W array models used by cache data/tag arrays: depth, width, mask granularity and output pipelining are parameters, and `R0_valid` reports when `R0_data` is meaningful. It sits directly under the array wrappers that the generated SRAM interfaces instantiate.

## Interface
- `DEPTH`, 64, number of entries; any value ≥ 2, power of two not required
- `WIDTH`, 1024, bits per entry
- `MASK_GRAN`, 1024, bits per mask segment; must divide `WIDTH`; `MASK_SEG = WIDTH/MASK_GRAN`
- `OUT_REG`, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle latency)
- `AW`, derived, `$clog2(DEPTH)`, not overridable
- `clock`  in  1  single clock, all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `init_done`  out  1  high once the clearing sweep has finished
- `R0_en`  in  1  read request
- `R0_addr`  in  AW  read address
- `R0_valid`  out  1  `R0_data` carries the result of a read issued at the stated latency
- `R0_data`  out  WIDTH  read data
- `W0_en`  in  1  write request
- `W0_addr`  in  AW  write address
- `W0_mask`  in  MASK_SEG  per-segment write enable
- `W0_data`  in  WIDTH  write data

## Operation
- Reset values: `init_done`=0, `R0_valid`=0, `R0_data`=0, sweep pointer=0, FSM=INIT.
- FSM states: INIT → READY.
  - INIT: one entry written to all-zero per cycle, pointer 0..DEPTH-1.
  - Transition to READY in the cycle after pointer DEPTH-1 is written.
- During INIT, `R0_en` and `W0_en` are ignored: no array update, no `R0_valid` pulse.
- READY write: segment i of `ram[W0_addr]` takes `W0_data[i*MASK_GRAN +: MASK_GRAN]` when `W0_mask[i]`=1. Unmasked segments are unchanged. All-zero mask is a no-op.
- READY read: the entry at `R0_addr` is returned with latency L (L=1 if `OUT_REG`=0, L=2 if `OUT_REG`=1). `R0_valid` pulses high for exactly the cycle the data is presented.
- Without a read, `R0_data` holds its last value; later writes to that address do not disturb it.
- Out-of-range address (≥ DEPTH):
  - Write is dropped.
  - Read returns all-zero with `R0_valid`=1.
- Same-address read and write in one cycle: behaviour set by `ARRAY_RW_BYPASS_EN` (see Configuration).
- Back-to-back reads every cycle are sustained at full throughput, including with `OUT_REG`=1.

## Timing
- `init_done` rises exactly DEPTH cycles after the first rising edge with `reset_n` high.
- Read issued at edge N: data valid after edge N+L.
- Write at edge N is visible to a read issued at edge N+1.
- `reset_n` asserted mid-INIT or mid-READY, at any time:
  - all outputs return to their reset values immediately;
  - pipelined reads in flight are discarded;
  - the sweep restarts from entry 0 after deassertion.
- Array contents are not reset asynchronously; only the sweep clears them.

## Configuration
- `ARRAY_RW_BYPASS_EN` defined: a same-address, same-cycle read returns the new data. Masked segments come from `W0_data`; unmasked segments are the old contents.
- `ARRAY_RW_BYPASS_EN` not defined: a same-address, same-cycle read returns the old contents (read-before-write).
- No other behaviour differs between the two builds.

## Structure
- Shared package `sram_array_pkg`:
  - init FSM state enum (`ST_INIT`, `ST_READY`);
  - helper function computing `MASK_SEG` and `AW`;
  - a localparam for the clear pattern (all-zero).
- One sub-module, `sram_array_init_ctrl`: sweep pointer, FSM and `init_done`. It outputs the sweep write address and enable, which are muxed ahead of the W0 port.
- Storage, mask merge, bypass and the output pipeline live in the top module.

## Test plan
- Reset, DEPTH=64: `init_done`=0 for 64 cycles, then 1. Read every address → all return 0 with `R0_valid`.
- `MASK_GRAN`=256, write addr 5, data all-ones, mask 4'b0101. Next cycle read addr 5 → segments 0 and 2 all-ones, segments 1 and 3 zero, after L cycles.
- `OUT_REG`=1: read addrs 1, 2, 3 on consecutive cycles after writing 0xA/0xB/0xC → data 0xA, 0xB, 0xC on cycles +2, +3, +4, with `R0_valid` high for exactly three cycles.
- Same-cycle write 0x55 / read addr 7 (old contents 0x11) → 0x55 with `ARRAY_RW_BYPASS_EN`, 0x11 without.
- DEPTH=48: write addr 50 dropped; read addr 50 → 0 with `R0_valid`=1; addr 47 is unaffected.
- Assert `reset_n` at sweep pointer 20, release, then count: `init_done` rises 48 cycles after release, and a read issued during INIT produces no `R0_valid`.
